fc_neuron_seq: RTL

//  Time-multiplexed fully-connected neuron. It streams an IN-element activation vector in beats of

---
 rtl/fc_pkg.sv | 21 ++
 rtl/lane_mul_sum.sv | 61 ++++++
 rtl/relu.sv | 17 +
 rtl/fc_neuron_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the time-multiplexed fully-connected neuron.
//   state_t : controller states (accumulate, drain pipeline, present result)
//   out_w   : full-precision result width for a WIDTH x WIDTH dot product of length IN
//   beats   : number of LANES-wide beats in an IN-element vector
package fc_pkg;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  function automatic int out_w(input int width, input int in_len);
    return 2 * width + $clog2(in_len);
  endfunction

  function automatic int beats(input int in_len, input int lanes);
    return in_len / lanes;
  endfunction

endpackage

// File: rtl/lane_mul_sum.sv
// LANES signed WIDTH x WIDTH multipliers with registered products, followed by a
// combinational adder tree over the registered products.
//   clk, rst : clock and synchronous active-high reset
//   i_en     : capture this cycle's products (a beat was accepted)
//   i_x      : LANES activations, lane k at [k*WIDTH +: WIDTH]
//   i_w      : LANES weights for the current beat, same lane layout
//   o_valid  : o_sum reflects products captured on the previous edge
//   o_sum    : signed sum of the registered products
module lane_mul_sum #(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int SW    = 2 * WIDTH + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [LANES*WIDTH-1:0]  i_x,
  input  logic [LANES*WIDTH-1:0]  i_w,
  output logic                    o_valid,
  output logic signed [SW-1:0]    o_sum
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] w_prod [LANES];
  logic signed [PW-1:0] r_prod [LANES];
  logic                 r_valid;
  logic signed [SW-1:0] w_sum;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [WIDTH-1:0] w_xk;
      logic signed [WIDTH-1:0] w_wk;
      assign w_xk = i_x[gi*WIDTH +: WIDTH];
      assign w_wk = i_w[gi*WIDTH +: WIDTH];
      // Operands widened first so the product is computed at full 2*WIDTH precision.
      assign w_prod[gi] = PW'(w_xk) * PW'(w_wk);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      for (int k = 0; k < LANES; k++) r_prod[k] <= '0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        for (int k = 0; k < LANES; k++) r_prod[k] <= w_prod[k];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) w_sum = w_sum + SW'(r_prod[k]);
  end

  assign o_valid = r_valid;
  assign o_sum   = w_sum;

endmodule

// File: rtl/relu.sv
// Two-input select used as a ReLU clamp: o_y = i_sel ? i_b : i_a.
//   i_a   : pass-through value (the accumulator)
//   i_b   : clamp value (zero)
//   i_sel : clamp select (accumulator sign bit)
//   o_y   : selected value
module relu #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed constant-weight neuron: accumulates an IN-element dot product
// LANES elements per beat, optionally clamps negatives to zero, and presents the
// result on a valid/ready output.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready/x : input beat handshake; lane k = x[k*WIDTH +: WIDTH]
//   out_valid/out_ready : result handshake; z held stable while out_valid=1
//   z                   : OW-bit result (signed, or >= 0 when RELU=1)
//   busy                : high from first accepted beat until the output handshake
module fc_neuron_seq
  import fc_pkg::*;
#(
  parameter  int                  WIDTH   = 8,
  parameter  int                  IN      = 128,
  parameter  int                  LANES   = 4,
  parameter  int                  RELU    = 1,
  parameter  logic [IN*WIDTH-1:0] WEIGHTS = '0,
  localparam int                  OW      = out_w(WIDTH, IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          z,
  output logic                   busy
);

  localparam int BEATS = beats(IN, LANES);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = 2 * WIDTH + $clog2(LANES);

  generate
    if ((IN % LANES) != 0 || LANES > IN) begin : g_bad_cfg
      $error("fc_neuron_seq: IN must be a multiple of LANES and LANES <= IN");
    end
  endgenerate

  state_t                r_state;
  logic [BCW-1:0]        r_beat_cnt;
  logic [1:0]            r_flush_cnt;
  logic signed [OW-1:0]  r_acc;
  logic [OW-1:0]         r_clamp;
  logic [OW-1:0]         r_z;
  logic                  r_out_valid;
  logic                  r_busy;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_sum_valid;
  logic signed [SW-1:0]  w_lane_sum;
  logic [OW-1:0]         w_clamp;
  logic [OW-1:0]         w_zero;
  logic [LANES*WIDTH-1:0] w_cur_w;
  logic [LANES*WIDTH-1:0] w_wslice [BEATS];

  // One constant slice of the weight vector per beat; beat_cnt picks among them.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wslice
      assign w_wslice[gi] = WEIGHTS[gi*LANES*WIDTH +: LANES*WIDTH];
    end
  endgenerate

  assign w_cur_w    = w_wslice[r_beat_cnt];
  assign w_in_ready = (r_state == S_ACC) && !rst;
  assign w_accept   = in_valid && w_in_ready;
  assign w_zero     = '0;

  lane_mul_sum #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lanes (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_accept),
    .i_x     (x),
    .i_w     (w_cur_w),
    .o_valid (w_sum_valid),
    .o_sum   (w_lane_sum)
  );

  generate
    if (RELU != 0) begin : g_relu
      relu #(.W(OW)) u_relu (
        .i_a   (r_acc),
        .i_b   (w_zero),
        .i_sel (r_acc[OW-1]),
        .o_y   (w_clamp)
      );
    end else begin : g_pass
      assign w_clamp = r_acc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_acc       <= '0;
      r_clamp     <= '0;
      r_z         <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Stage 2: fold the previous beat's lane sum into the accumulator.
      if (w_sum_valid) r_acc <= r_acc + OW'(w_lane_sum);

      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (r_beat_cnt == BCW'(BEATS - 1)) begin
              r_beat_cnt  <= '0;
              r_flush_cnt <= '0;
              r_state     <= S_FLUSH;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        // Count 0: last lane sum lands in acc. Count 1: clamp captured into its own
        // register so the ReLU mux is not chained behind the accumulator adder.
        // Count 2: result presented.
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
          if (r_flush_cnt == 2'd1) r_clamp <= w_clamp;
          if (r_flush_cnt == 2'd2) begin
            r_z         <= r_clamp;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_acc       <= '0;
            r_state     <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign busy      = r_busy;

endmodule
